// File: rtl/eh2_lsu_dccm_wr_sched_if.sv
// Bundle of the DCCM write scheduler's request, acknowledge and write-port signals.
// The slave view is taken by the scheduler. The master view is taken by whoever drives
// the ECC, DMA and store-buffer requests and observes the DCCM write port.
interface eh2_lsu_dccm_wr_sched_if #(
    parameter int DCCM_BITS       = 16,
    parameter int DCCM_DATA_WIDTH = 32
);
    logic                       dec_tlu_core_ecc_disable;
    logic                       ecc_corr_valid;
    logic                       ecc_corr_lo_err;
    logic                       ecc_corr_hi_err;
    logic [DCCM_BITS-1:0]       ecc_corr_addr_lo;
    logic [DCCM_BITS-1:0]       ecc_corr_addr_hi;
    logic [DCCM_DATA_WIDTH-1:0] ecc_corr_data_lo;
    logic [DCCM_DATA_WIDTH-1:0] ecc_corr_data_hi;
    logic                       ecc_corr_busy;
    logic                       ecc_corr_drop;

    logic                       dma_wr_req;
    logic [DCCM_BITS-1:0]       dma_wr_addr_lo;
    logic [DCCM_BITS-1:0]       dma_wr_addr_hi;
    logic [DCCM_DATA_WIDTH-1:0] dma_wr_data_lo;
    logic [DCCM_DATA_WIDTH-1:0] dma_wr_data_hi;
    logic                       dma_wr_ack;

    logic                       stbuf_req;
    logic [DCCM_BITS-1:0]       stbuf_addr;
    logic [DCCM_DATA_WIDTH-1:0] stbuf_data;
    logic                       stbuf_ack;

    logic                       dccm_wren;
    logic [DCCM_BITS-1:0]       dccm_wr_addr_lo;
    logic [DCCM_BITS-1:0]       dccm_wr_addr_hi;
    logic [DCCM_DATA_WIDTH-1:0] dccm_wr_data_lo;
    logic [DCCM_DATA_WIDTH-1:0] dccm_wr_data_hi;
    logic [1:0]                 dccm_wr_src;

    modport slave (
        input  dec_tlu_core_ecc_disable,
        input  ecc_corr_valid, ecc_corr_lo_err, ecc_corr_hi_err,
        input  ecc_corr_addr_lo, ecc_corr_addr_hi, ecc_corr_data_lo, ecc_corr_data_hi,
        output ecc_corr_busy, ecc_corr_drop,
        input  dma_wr_req, dma_wr_addr_lo, dma_wr_addr_hi, dma_wr_data_lo, dma_wr_data_hi,
        output dma_wr_ack,
        input  stbuf_req, stbuf_addr, stbuf_data,
        output stbuf_ack,
        output dccm_wren, dccm_wr_addr_lo, dccm_wr_addr_hi,
        output dccm_wr_data_lo, dccm_wr_data_hi, dccm_wr_src
    );

    modport master (
        output dec_tlu_core_ecc_disable,
        output ecc_corr_valid, ecc_corr_lo_err, ecc_corr_hi_err,
        output ecc_corr_addr_lo, ecc_corr_addr_hi, ecc_corr_data_lo, ecc_corr_data_hi,
        input  ecc_corr_busy, ecc_corr_drop,
        output dma_wr_req, dma_wr_addr_lo, dma_wr_addr_hi, dma_wr_data_lo, dma_wr_data_hi,
        input  dma_wr_ack,
        output stbuf_req, stbuf_addr, stbuf_data,
        input  stbuf_ack,
        input  dccm_wren, dccm_wr_addr_lo, dccm_wr_addr_hi,
        input  dccm_wr_data_lo, dccm_wr_data_hi, dccm_wr_src
    );
endinterface

// File: rtl/eh2_lsu_dccm_wr_sched.sv
// DCCM write-port scheduler.
// Three requesters share the single write port: ECC correction write-back, DMA and
// store-buffer drain. At most one write is issued per cycle. A correction job is
// captured in one cycle and replayed as LO and/or HI bank writes in the following
// cycles. A saturating counter stops a continuous DMA stream from starving the store buffer.
module eh2_lsu_dccm_wr_sched #(
    parameter int DCCM_BITS       = 16,
    parameter int DCCM_DATA_WIDTH = 32,
    parameter int STARVE_MAX      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    eh2_lsu_dccm_wr_sched_if.slave  bus
);
    localparam int AW = DCCM_BITS;
    localparam int DW = DCCM_DATA_WIDTH;
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t          state_reg;
    logic            busy_reg;
    logic            job_hi_err_reg;
    logic [AW-1:0]   job_addr_lo_reg;
    logic [AW-1:0]   job_addr_hi_reg;
    logic [DW-1:0]   job_data_lo_reg;
    logic [DW-1:0]   job_data_hi_reg;
    logic [CW-1:0]   starve_cnt_reg;

    logic            job_req;
    logic            capture;
    logic            ecc_active;
    logic            stbuf_forced;
    logic            ecc_win;
    logic            dma_win;
    logic            stbuf_win;

    // A job is worth taking only if ECC is enabled and at least one bank is bad;
    // it is taken only when the FSM is IDLE at this clock edge.
    assign job_req      = bus.ecc_corr_valid & ~bus.dec_tlu_core_ecc_disable
                        & (bus.ecc_corr_lo_err | bus.ecc_corr_hi_err);
    assign capture      = (state_reg == IDLE) & job_req;
    assign ecc_active   = (state_reg == WR_LO) | (state_reg == WR_HI);
    assign stbuf_forced = bus.stbuf_req & (starve_cnt_reg == STARVE_LIM);

    // Fixed-priority arbitration: correction write, forced drain, DMA, normal drain.
    // Everything is held off while reset is asserted so no output toggles under reset.
    always_comb begin
        ecc_win   = 1'b0;
        dma_win   = 1'b0;
        stbuf_win = 1'b0;
        if (!rst) begin
            if (ecc_active) begin
                ecc_win = 1'b1;
            end else if (stbuf_forced) begin
                stbuf_win = 1'b1;
            end else if (bus.dma_wr_req) begin
                dma_win = 1'b1;
            end else if (bus.stbuf_req) begin
                stbuf_win = 1'b1;
            end
        end
    end

    // Per-bank write-data selection; bank 0 is LO, bank 1 is HI.
    logic [1:0][AW-1:0] ecc_addr, dma_addr, wr_addr;
    logic [1:0][DW-1:0] ecc_data, dma_data, wr_data;

    assign ecc_addr[0] = job_addr_lo_reg;
    assign ecc_addr[1] = job_addr_hi_reg;
    assign ecc_data[0] = job_data_lo_reg;
    assign ecc_data[1] = job_data_hi_reg;
    assign dma_addr[0] = bus.dma_wr_addr_lo;
    assign dma_addr[1] = bus.dma_wr_addr_hi;
    assign dma_data[0] = bus.dma_wr_data_lo;
    assign dma_data[1] = bus.dma_wr_data_hi;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            assign wr_addr[gi] = ecc_win   ? ecc_addr[gi]   :
                                 dma_win   ? dma_addr[gi]   :
                                 stbuf_win ? bus.stbuf_addr : '0;
            assign wr_data[gi] = ecc_win   ? ecc_data[gi]   :
                                 dma_win   ? dma_data[gi]   :
                                 stbuf_win ? bus.stbuf_data : '0;
        end
    endgenerate

    assign bus.dccm_wren       = ecc_win | dma_win | stbuf_win;
    assign bus.dccm_wr_src     = {ecc_win | dma_win, ecc_win | stbuf_win};
    assign bus.dccm_wr_addr_lo = wr_addr[0];
    assign bus.dccm_wr_addr_hi = wr_addr[1];
    assign bus.dccm_wr_data_lo = wr_data[0];
    assign bus.dccm_wr_data_hi = wr_data[1];
    assign bus.dma_wr_ack      = dma_win;
    assign bus.stbuf_ack       = stbuf_win;
    assign bus.ecc_corr_busy   = busy_reg;
    assign bus.ecc_corr_drop   = ~rst & job_req & (state_reg != IDLE);

    // Correction FSM: capture a job in IDLE, then write LO and/or HI on later cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            busy_reg        <= 1'b0;
            job_hi_err_reg  <= 1'b0;
            job_addr_lo_reg <= '0;
            job_addr_hi_reg <= '0;
            job_data_lo_reg <= '0;
            job_data_hi_reg <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (capture) begin
                        job_hi_err_reg  <= bus.ecc_corr_hi_err;
                        job_addr_lo_reg <= bus.ecc_corr_addr_lo;
                        job_addr_hi_reg <= bus.ecc_corr_addr_hi;
                        job_data_lo_reg <= bus.ecc_corr_data_lo;
                        job_data_hi_reg <= bus.ecc_corr_data_hi;
                        state_reg       <= bus.ecc_corr_lo_err ? WR_LO : WR_HI;
                        busy_reg        <= 1'b1;
                    end
                end
                WR_LO: begin
                    if (job_hi_err_reg) begin
                        state_reg <= WR_HI;
                    end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                WR_HI: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Starvation counter: counts DMA wins over a waiting drain and saturates.
    // It holds across correction writes and clears once the drain is served or withdrawn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else if (!bus.stbuf_req) begin
            starve_cnt_reg <= '0;
        end else if (ecc_win) begin
            starve_cnt_reg <= starve_cnt_reg;
        end else if (stbuf_win) begin
            starve_cnt_reg <= '0;
        end else if (dma_win && (starve_cnt_reg != STARVE_LIM)) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end
endmodule
